// File: rtl/multu_hilo_unit_if.sv
// Execute-stage multiply/HI-LO bus: ALU control drives the request side,
// the multiply unit returns status, HI/LO and MFHI/MFLO read data.
interface multu_hilo_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [5:0]       funct;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             done;
   logic             stall;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] rd_data;

   modport master (
      output start, funct, op_a, op_b,
      input  busy, done, stall, hi, lo, rd_data
   );

   modport slave (
      input  start, funct, op_a, op_b,
      output busy, done, stall, hi, lo, rd_data
   );
endinterface

// File: rtl/multu_hilo_unit.sv
// Sequential unsigned shift-add multiplier (one multiplier bit per clock)
// that owns the architectural HI/LO registers and serves MFHI/MFLO reads.
module multu_hilo_unit #(
   parameter int         WIDTH   = 32,
   parameter logic [5:0] F_MULTU = 6'b011001,
   parameter logic [5:0] F_MFHI  = 6'b010000,
   parameter logic [5:0] F_MFLO  = 6'b010010
) (
   input logic              clk,
   input logic              rst,
   multu_hilo_unit_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [2*WIDTH:0]     acc_q, acc_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;

   logic                 accept;
   logic [WIDTH:0]       upper_sum;
   logic [2*WIDTH:0]     acc_shift;

   assign accept = bus.start && (bus.funct == F_MULTU);

   // Upper half keeps WIDTH+1 bits so the add carry survives into the shift.
   assign upper_sum = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : '0);
   assign acc_shift = {upper_sum, acc_q[WIDTH-1:0]} >> 1;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               mcand_d = bus.op_a;
               acc_d   = {{(WIDTH+1){1'b0}}, bus.op_b};
               count_d = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d   = acc_shift;
            count_d = count_q + 1'b1;
            if (count_q == CNT_W'(WIDTH - 1)) begin
               hi_d    = acc_shift[2*WIDTH-1:WIDTH];
               lo_d    = acc_shift[WIDTH-1:0];
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Multiplicand is only meaningful in RUN, which is always entered by a fresh load.
   always_ff @(posedge clk) begin
      mcand_q <= mcand_d;
   end

   assign bus.busy  = (state_q == S_RUN);
   assign bus.done  = (state_q == S_DONE);
   assign bus.stall = (state_q == S_RUN) || ((state_q == S_IDLE) && accept);
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;

   always_comb begin
      case (bus.funct)
         F_MFHI:  bus.rd_data = hi_q;
         F_MFLO:  bus.rd_data = lo_q;
         default: bus.rd_data = '0;
      endcase
   end
endmodule

// File: tb/tb_multu_hilo_unit.sv
// Bench for multu_hilo_unit: directed vector table, hand sequences for
// reset/ignore cases, and random operands against a plain-multiply model.
module tb_multu_hilo_unit;
   localparam int         W       = 32;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_ADD   = 6'b100000;

   logic clk = 1'b0;
   logic rst;

   multu_hilo_unit_if #(.WIDTH(W)) bus ();

   multu_hilo_unit #(
      .WIDTH  (W),
      .F_MULTU(F_MULTU),
      .F_MFHI (F_MFHI),
      .F_MFLO (F_MFLO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Architectural HI/LO as the model sees them.
   logic [W-1:0] mhi = '0;
   logic [W-1:0] mlo = '0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           inj;
      bit           sid;
      string        name;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [63:0] aa;
      logic [63:0] bb;
      aa = {32'b0, a};
      bb = {32'b0, b};
      return aa * bb;
   endfunction

   // One full MULTU transaction with timing, stall, readout and pulse checks.
   task automatic mult(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el,
                       input int inj, input bit sid, input string nm,
                       output int acc_cyc);
      int busy_n;
      int stall_bad;
      bit seen;
      bus.start = 1'b1;
      bus.funct = F_MULTU;
      bus.op_a  = a;
      bus.op_b  = b;
      #1 chk({nm, " stall_accept"}, 64'(bus.stall), 64'(1));
      step();
      acc_cyc   = cyc;
      bus.start = 1'b0;
      bus.op_a  = $urandom;
      bus.op_b  = $urandom;
      busy_n    = 0;
      stall_bad = 0;
      seen      = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         if (bus.busy) busy_n++;
         if (!bus.stall) stall_bad++;
         if (i == 5) begin
            bus.funct = F_MFLO;
            #1 chk({nm, " rd_lo_run"}, 64'(bus.rd_data), 64'(mlo));
            bus.funct = F_MFHI;
            #1 chk({nm, " rd_hi_run"}, 64'(bus.rd_data), 64'(mhi));
            bus.funct = F_ADD;
            #1 chk({nm, " rd_other_run"}, 64'(bus.rd_data), 64'(0));
            bus.funct = F_MULTU;
         end
         if (i == inj) begin
            bus.start = 1'b1;
            bus.funct = F_MULTU;
            bus.op_a  = 32'd7;
            bus.op_b  = 32'd7;
         end
         step();
         bus.start = 1'b0;
      end
      chk({nm, " done_seen"}, 64'(seen), 64'(1));
      chk({nm, " latency"}, 64'(cyc - acc_cyc), 64'(32));
      chk({nm, " busy_cycles"}, 64'(busy_n), 64'(32));
      chk({nm, " stall_run"}, 64'(stall_bad), 64'(0));
      chk({nm, " busy_in_done"}, 64'(bus.busy), 64'(0));
      chk({nm, " stall_in_done"}, 64'(bus.stall), 64'(0));
      chk({nm, " hi"}, 64'(bus.hi), 64'(eh));
      chk({nm, " lo"}, 64'(bus.lo), 64'(el));
      if (sid) begin
         bus.start = 1'b1;
         bus.funct = F_MULTU;
      end
      step();
      bus.start = 1'b0;
      chk({nm, " done_one_pulse"}, 64'(bus.done), 64'(0));
      if (sid) chk({nm, " start_in_done_ignored"}, 64'(bus.busy), 64'(0));
      bus.funct = F_MFHI;
      #1 chk({nm, " mfhi"}, 64'(bus.rd_data), 64'(eh));
      bus.funct = F_MFLO;
      #1 chk({nm, " mflo"}, 64'(bus.rd_data), 64'(el));
      mhi = eh;
      mlo = el;
   endtask

   initial begin
      int ac0;
      int ac1;
      int dn;
      logic [63:0] p;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      tbl[0] = '{32'd3, 32'd5, 32'h0, 32'hF, -1, 1'b0, "basic"};
      tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, -1, 1'b1, "max"};
      tbl[2] = '{32'h8000_0000, 32'd2, 32'h1, 32'h0, -1, 1'b0, "msb_x2"};
      tbl[3] = '{32'h1234, 32'h5678, 32'h0, 32'h0626_0060, 10, 1'b0, "start_busy"};
      tbl[4] = '{32'h8000_0001, 32'd2, 32'h1, 32'h2, -1, 1'b0, "prior"};

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.funct = 6'd0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      repeat (2) step();
      rst = 1'b0;
      chk("reset hi", 64'(bus.hi), 64'(0));
      chk("reset lo", 64'(bus.lo), 64'(0));
      chk("reset busy", 64'(bus.busy), 64'(0));
      chk("reset done", 64'(bus.done), 64'(0));
      chk("reset stall", 64'(bus.stall), 64'(0));

      // Start with a non-MULTU funct must not touch the unit.
      bus.start = 1'b1;
      bus.funct = F_MFHI;
      #1 chk("nonmult stall", 64'(bus.stall), 64'(0));
      step();
      bus.start = 1'b0;
      chk("nonmult busy", 64'(bus.busy), 64'(0));
      chk("nonmult hi", 64'(bus.hi), 64'(0));

      for (int i = 0; i < 5; i++) begin
         mult(tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].inj, tbl[i].sid, tbl[i].name, ac0);
      end

      // Reset in the middle of a multiply aborts it without a result.
      bus.start = 1'b1;
      bus.funct = F_MULTU;
      bus.op_a  = 32'hDEAD_BEEF;
      bus.op_b  = 32'h1234_5678;
      step();
      bus.start = 1'b0;
      repeat (14) step();
      chk("midrst busy_before", 64'(bus.busy), 64'(1));
      rst = 1'b1;
      step();
      rst = 1'b0;
      mhi = '0;
      mlo = '0;
      chk("midrst hi", 64'(bus.hi), 64'(0));
      chk("midrst lo", 64'(bus.lo), 64'(0));
      chk("midrst busy", 64'(bus.busy), 64'(0));
      chk("midrst done", 64'(bus.done), 64'(0));
      dn = 0;
      repeat (40) begin
         step();
         if (bus.done) dn++;
      end
      chk("midrst no_done", 64'(dn), 64'(0));
      mult(32'h10, 32'h10, 32'h0, 32'h100, -1, 1'b0, "after_rst", ac0);

      // Back-to-back: second start in the first IDLE cycle after done.
      ra = $urandom;
      rb = $urandom;
      p  = model_prod(ra, rb);
      mult(ra, rb, p[63:32], p[31:0], -1, 1'b0, "b2b_first", ac0);
      ra = $urandom;
      rb = $urandom;
      p  = model_prod(ra, rb);
      mult(ra, rb, p[63:32], p[31:0], -1, 1'b0, "b2b_second", ac1);
      chk("b2b spacing", 64'(ac1 - ac0), 64'(34));

      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
         p  = model_prod(ra, rb);
         mult(ra, rb, p[63:32], p[31:0], (i % 2 == 0) ? int'($urandom_range(0, 30)) : -1,
              1'(i % 2), "random", ac0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
